// File: rtl/pcileech_panel_ctl.sv
// Front-panel controller: synchronises and debounces the two buttons, derives soft reset and
// long-press config reload from SW2, and drives the activity/blink LEDs (active low).
module pcileech_panel_ctl #(
   parameter int DEBOUNCE_CYCLES   = 1000000,
   parameter int LONGPRESS_CYCLES  = 500000000,
   parameter int STRETCH_CYCLES    = 2000000,
   parameter int BLINK_BIT         = 24,
   parameter int BLINK_WINDOW_BITS = 27
) (
   input  logic clk,
   input  logic rst,
   input  logic user_sw1_n,
   input  logic user_sw2_n,
   input  logic led_pcie_act,
   input  logic led_com_act,
   output logic sw1_pressed,
   output logic sw2_pressed,
   output logic soft_rst,
   output logic cfg_reload,
   output logic cfg_reload_pulse,
   output logic user_ld1_n,
   output logic user_ld2_n
);

   localparam int DB_W = $clog2(DEBOUNCE_CYCLES) + 1;
   localparam int LP_W = $clog2(LONGPRESS_CYCLES) + 1;
   localparam int ST_W = $clog2(STRETCH_CYCLES) + 1;

   typedef enum logic [1:0] {IDLE, HELD, LONG} state_t;

   logic [1:0]  pad;
   logic [1:0]  stable;
   logic [1:0]  act;
   logic [1:0]  lit;
   logic [63:0] uptime_reg;
   logic        soft_rst_reg;
   state_t      state_reg, state_next;
   logic [LP_W-1:0] hold_reg, hold_next;
   logic        pulse_reg, pulse_next;
   logic        ld1_reg, ld2_reg;
   logic        blink;
   logic        led_invert;

   assign pad = {user_sw2_n, user_sw1_n};
   assign act = {led_com_act, led_pcie_act};

   // Bit 0 is SW1, bit 1 is SW2; both follow the same sync + debounce path.
   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_btn
         logic            sync1_reg, sync2_reg;
         logic            stable_reg;
         logic [DB_W-1:0] db_cnt_reg;
         logic            sync_val;

         assign sync_val   = ~sync2_reg;
         assign stable[gi] = stable_reg;

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               sync1_reg  <= 1'b1;
               sync2_reg  <= 1'b1;
               stable_reg <= 1'b0;
               db_cnt_reg <= '0;
            end else begin
               sync1_reg <= pad[gi];
               sync2_reg <= sync1_reg;
               if (sync_val != stable_reg) begin
                  if (db_cnt_reg == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                     stable_reg <= sync_val;
                     db_cnt_reg <= '0;
                  end else begin
                     db_cnt_reg <= db_cnt_reg + 1'b1;
                  end
               end else begin
                  db_cnt_reg <= '0;
               end
            end
         end
      end
   endgenerate

   assign sw1_pressed = stable[0];
   assign sw2_pressed = stable[1];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         uptime_reg   <= '0;
         soft_rst_reg <= 1'b1;
      end else begin
         soft_rst_reg <= sw2_pressed | (uptime_reg < 64'd64);
         if (sw2_pressed)
            uptime_reg <= '0;
         else if (uptime_reg != {64{1'b1}})
            uptime_reg <= uptime_reg + 64'd1;
      end
   end

   assign soft_rst = soft_rst_reg;

   // Hold counter tracks consecutive pressed cycles, so it reads 0 whenever the FSM is in IDLE.
   always_comb begin
      state_next = state_reg;
      hold_next  = '0;
      pulse_next = 1'b0;
      if (sw2_pressed)
         hold_next = (hold_reg == LP_W'(LONGPRESS_CYCLES)) ? hold_reg : hold_reg + 1'b1;
      case (state_reg)
         IDLE: begin
            if (sw2_pressed)
               state_next = HELD;
         end
         HELD: begin
            if (!sw2_pressed) begin
               state_next = IDLE;
            end else if (hold_reg == LP_W'(LONGPRESS_CYCLES - 1)) begin
               state_next = LONG;
               pulse_next = 1'b1;
            end
         end
         LONG: begin
            if (!sw2_pressed)
               state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= IDLE;
         hold_reg  <= '0;
         pulse_reg <= 1'b0;
      end else begin
         state_reg <= state_next;
         hold_reg  <= hold_next;
         pulse_reg <= pulse_next;
      end
   end

   assign cfg_reload       = (state_reg == LONG);
   assign cfg_reload_pulse = pulse_reg;

   // Bit 0 stretches PCIe activity, bit 1 stretches COM activity.
   generate
      for (gi = 0; gi < 2; gi++) begin : g_str
         logic [ST_W-1:0] st_cnt_reg;

         assign lit[gi] = act[gi] | (st_cnt_reg != '0);

         always_ff @(posedge clk or posedge rst) begin
            if (rst)
               st_cnt_reg <= '0;
            else if (act[gi])
               st_cnt_reg <= ST_W'(STRETCH_CYCLES - 1);
            else if (st_cnt_reg != '0)
               st_cnt_reg <= st_cnt_reg - 1'b1;
         end
      end
   endgenerate

   assign blink      = uptime_reg[BLINK_BIT] & ((uptime_reg >> BLINK_WINDOW_BITS) == 64'd0);
   assign led_invert = sw1_pressed ^ blink;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ld1_reg <= 1'b1;
         ld2_reg <= 1'b1;
      end else begin
         ld1_reg <= ~lit[0];
         ld2_reg <= ~(lit[1] ^ led_invert);
      end
   end

   assign user_ld1_n = ld1_reg;
   assign user_ld2_n = ld2_reg;

endmodule

// File: tb/tb_pcileech_panel_ctl.sv
// Bench for pcileech_panel_ctl: directed scenarios with literal checks, then random pad/activity
// stimulus, all compared every cycle against an in-bench behavioural model.
module tb_pcileech_panel_ctl;

   localparam int DEB = 4;
   localparam int LP  = 20;
   localparam int ST  = 8;
   localparam int BB  = 2;
   localparam int WB  = 5;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic user_sw1_n = 1'b1;
   logic user_sw2_n = 1'b1;
   logic led_pcie_act = 1'b0;
   logic led_com_act = 1'b0;
   logic sw1_pressed, sw2_pressed, soft_rst, cfg_reload, cfg_reload_pulse;
   logic user_ld1_n, user_ld2_n;

   int vectors = 0;
   int errors  = 0;
   bit run_cmp = 1'b0;

   pcileech_panel_ctl #(
      .DEBOUNCE_CYCLES(DEB),
      .LONGPRESS_CYCLES(LP),
      .STRETCH_CYCLES(ST),
      .BLINK_BIT(BB),
      .BLINK_WINDOW_BITS(WB)
   ) dut (
      .clk(clk),
      .rst(rst),
      .user_sw1_n(user_sw1_n),
      .user_sw2_n(user_sw2_n),
      .led_pcie_act(led_pcie_act),
      .led_com_act(led_com_act),
      .sw1_pressed(sw1_pressed),
      .sw2_pressed(sw2_pressed),
      .soft_rst(soft_rst),
      .cfg_reload(cfg_reload),
      .cfg_reload_pulse(cfg_reload_pulse),
      .user_ld1_n(user_ld1_n),
      .user_ld2_n(user_ld2_n)
   );

   always #5 clk = ~clk;

   // Behavioural model: pad history, run lengths and ages rather than the design's counters.
   logic [1:0] m_d1 = 2'b11, m_d2 = 2'b11, m_stable = 2'b00;
   int m_drun [2] = '{0, 0};
   int m_age  [2] = '{ST, ST};
   longint unsigned m_up = 0;
   int m_run2 = 0;
   logic e_soft = 1'b1, e_cfg = 1'b0, e_pulse = 1'b0, e_ld1 = 1'b1, e_ld2 = 1'b1;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_d1 = 2'b11; m_d2 = 2'b11; m_stable = 2'b00;
         m_drun[0] = 0; m_drun[1] = 0;
         m_age[0] = ST; m_age[1] = ST;
         m_up = 0; m_run2 = 0;
         e_soft = 1'b1; e_cfg = 1'b0; e_pulse = 1'b0; e_ld1 = 1'b1; e_ld2 = 1'b1;
      end else begin
         bit sw1, sw2, lit_p, lit_c, blink, sync;
         sw1   = m_stable[0];
         sw2   = m_stable[1];
         lit_p = led_pcie_act || (m_age[0] < ST - 1);
         lit_c = led_com_act  || (m_age[1] < ST - 1);
         blink = m_up[BB] && ((m_up >> WB) == 0);
         e_ld1  = !lit_p;
         e_ld2  = !(lit_c ^ sw1 ^ blink);
         e_soft = sw2 || (m_up < 64);
         m_run2 = sw2 ? m_run2 + 1 : 0;
         e_cfg   = (m_run2 >= LP);
         e_pulse = (m_run2 == LP);
         if (sw2) m_up = 0;
         else if (m_up != 64'hFFFF_FFFF_FFFF_FFFF) m_up = m_up + 1;
         m_age[0] = led_pcie_act ? 0 : (m_age[0] < 1000 ? m_age[0] + 1 : m_age[0]);
         m_age[1] = led_com_act  ? 0 : (m_age[1] < 1000 ? m_age[1] + 1 : m_age[1]);
         for (int i = 0; i < 2; i++) begin
            sync = ~m_d2[i];
            if (sync != m_stable[i]) begin
               m_drun[i] = m_drun[i] + 1;
               if (m_drun[i] == DEB) begin
                  m_stable[i] = sync;
                  m_drun[i] = 0;
               end
            end else begin
               m_drun[i] = 0;
            end
         end
         m_d2 = m_d1;
         m_d1 = {user_sw2_n, user_sw1_n};
      end
   end

   task automatic cmp(input string name, input logic actual, input logic expected);
      if (actual !== expected) begin
         errors++;
         $display("FAIL %s at %0t: got %b expected %b", name, $time, actual, expected);
      end
   endtask

   always @(negedge clk) begin
      if (run_cmp) begin
         vectors++;
         cmp("sw1_pressed", sw1_pressed, m_stable[0]);
         cmp("sw2_pressed", sw2_pressed, m_stable[1]);
         cmp("soft_rst", soft_rst, e_soft);
         cmp("cfg_reload", cfg_reload, e_cfg);
         cmp("cfg_reload_pulse", cfg_reload_pulse, e_pulse);
         cmp("user_ld1_n", user_ld1_n, e_ld1);
         cmp("user_ld2_n", user_ld2_n, e_ld2);
      end
   end

   task automatic lit_chk(input string name, input logic actual, input logic expected);
      vectors++;
      if (actual !== expected) begin
         errors++;
         $display("FAIL lit_%s at %0t: got %b expected %b", name, $time, actual, expected);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic strobe_pcie();
      led_pcie_act = 1'b1; cyc(1); led_pcie_act = 1'b0;
   endtask

   initial begin
      int sw_left [2];
      logic [1:0] sw_val;
      sw_left[0] = 0; sw_left[1] = 0; sw_val = 2'b11;

      cyc(3);
      run_cmp = 1'b1;
      rst = 1'b0;
      // Power-on: soft reset for 64 cycles, blink on LED2 early in uptime.
      cyc(1);
      lit_chk("por_soft", soft_rst, 1'b1);
      lit_chk("por_sw2", sw2_pressed, 1'b0);
      lit_chk("por_ld1", user_ld1_n, 1'b1);
      cyc(1);  lit_chk("blink_off", user_ld2_n, 1'b1);
      cyc(4);  lit_chk("blink_on", user_ld2_n, 1'b0);
      cyc(58); lit_chk("soft_64", soft_rst, 1'b1);
      cyc(1);  lit_chk("soft_65", soft_rst, 1'b0);
      lit_chk("blink_done", user_ld2_n, 1'b1);

      // SW2 glitch shorter than debounce, then a 10-cycle press.
      user_sw2_n = 1'b0; cyc(3); user_sw2_n = 1'b1;
      cyc(10); lit_chk("glitch", sw2_pressed, 1'b0);
      user_sw2_n = 1'b0;
      cyc(5); lit_chk("deb_5", sw2_pressed, 1'b0);
      cyc(1); lit_chk("deb_6", sw2_pressed, 1'b1);
      cyc(1); lit_chk("srst_7", soft_rst, 1'b1);
      cyc(3); user_sw2_n = 1'b1;
      cyc(20);

      // Long press of 30 cycles.
      user_sw2_n = 1'b0;
      cyc(25); lit_chk("long_25", cfg_reload, 1'b0);
      cyc(1);  lit_chk("long_26", cfg_reload, 1'b1);
      lit_chk("pulse_26", cfg_reload_pulse, 1'b1);
      cyc(1);  lit_chk("pulse_27", cfg_reload_pulse, 1'b0);
      cyc(3);  user_sw2_n = 1'b1;
      cyc(6);  lit_chk("rel_cfg_36", cfg_reload, 1'b1);
      lit_chk("rel_sw2_36", sw2_pressed, 1'b0);
      cyc(1);  lit_chk("rel_cfg_37", cfg_reload, 1'b0);
      cyc(10);

      // Short hold, then reset in the middle of a press.
      user_sw2_n = 1'b0; cyc(15); user_sw2_n = 1'b1;
      cyc(15);
      user_sw2_n = 1'b0; cyc(16);
      #2 rst = 1'b1;
      cyc(1);
      lit_chk("rst_sw2", sw2_pressed, 1'b0);
      lit_chk("rst_soft", soft_rst, 1'b1);
      lit_chk("rst_cfg", cfg_reload, 1'b0);
      lit_chk("rst_ld2", user_ld2_n, 1'b1);
      rst = 1'b0;
      cyc(30); user_sw2_n = 1'b1;
      cyc(80);

      // PCIe stretcher: single strobe, then retrigger.
      strobe_pcie();
      cyc(7); lit_chk("str_8", user_ld1_n, 1'b0);
      cyc(1); lit_chk("str_9", user_ld1_n, 1'b1);
      cyc(3);
      strobe_pcie(); cyc(4); strobe_pcie();
      cyc(7); lit_chk("retrig_13", user_ld1_n, 1'b0);
      cyc(1); lit_chk("retrig_14", user_ld1_n, 1'b1);

      // SW1 inverts LED2 after the blink window; COM activity turns it off.
      user_sw1_n = 1'b0;
      cyc(8); lit_chk("inv_on", user_ld2_n, 1'b0);
      led_com_act = 1'b1; cyc(1); led_com_act = 1'b0;
      lit_chk("inv_com_1", user_ld2_n, 1'b1);
      cyc(7); lit_chk("inv_com_8", user_ld2_n, 1'b1);
      cyc(1); lit_chk("inv_com_9", user_ld2_n, 1'b0);
      user_sw1_n = 1'b1;
      cyc(10);

      // Randomised pads, activity strobes and occasional async reset.
      for (int n = 0; n < 4000; n++) begin
         @(negedge clk);
         if (rst) rst = 1'b0;
         else if ($urandom_range(0, 599) == 0) begin #2 rst = 1'b1; end
         for (int i = 0; i < 2; i++) begin
            if (sw_left[i] == 0) begin
               sw_val[i]  = 1'($urandom_range(0, 1));
               sw_left[i] = $urandom_range(1, 40);
            end
            sw_left[i]--;
         end
         user_sw1_n   = sw_val[0];
         user_sw2_n   = sw_val[1];
         led_pcie_act = ($urandom_range(0, 9) == 0);
         led_com_act  = ($urandom_range(0, 9) == 0);
      end
      cyc(2);
      run_cmp = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
